// File: rtl/alu_mc_sequencer.sv
// Macro-op sequencer that drives a combinational 8-bit ALU and returns a registered response.
// SINGLE/CMP/PAR take one ALU cycle; MUL performs a fixed-length shift-add loop on the same ALU.
package alu_mc_defs_pkg;
  typedef enum logic [2:0] {
    mcADD = 3'd0, mcSUB = 3'd1, mcAND = 3'd2, mcOR = 3'd3,
    mcXOR = 3'd4, mcRXR = 3'd5, mcLSL = 3'd6, mcLSR = 3'd7
  } op_mne;

  typedef enum logic [1:0] {
    CMD_SINGLE = 2'd0, CMD_MUL = 2'd1, CMD_CMP = 2'd2, CMD_PAR = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0, EXEC = 3'd1, MUL_ADD = 3'd2, MUL_SHA = 3'd3, MUL_SHB = 3'd4, RESP = 3'd5
  } state_e;
endpackage

module alu_mc_sequencer
  import alu_mc_defs_pkg::*;
#(
  parameter int MUL_ITERS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [1:0] ReqCmd,
  input  logic [2:0] ReqOp,
  input  logic [7:0] ReqA,
  input  logic [7:0] ReqB,
  output logic       RspValid,
  input  logic       RspReady,
  output logic [7:0] RspData,
  output logic       RspEq,
  output logic       RspLt,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [2:0] AluOp,
  input  logic [7:0] AluOut,
  input  logic       AluEq,
  input  logic       AluLt,
  output logic [2:0] DbgState
);

  localparam int CW = $clog2(MUL_ITERS + 1);

  state_e        state, state_nxt;
  logic [1:0]    cmd;
  logic [2:0]    op;
  logic [7:0]    a, b, acc;
  logic [CW-1:0] cnt;
  logic          last_iter;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The request side is ready only in IDLE; the response stays valid and stable until taken.
  assign ReqReady  = (state == IDLE) && Reset;
  assign RspValid  = (state == RESP);
  assign DbgState  = state;
  assign last_iter = (cnt == CW'(MUL_ITERS - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cmd     <= 2'd0;
      op      <= 3'd0;
      a       <= 8'd0;
      b       <= 8'd0;
      acc     <= 8'd0;
      cnt     <= '0;
      RspData <= 8'd0;
      RspEq   <= 1'b0;
      RspLt   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            cmd <= ReqCmd;
            op  <= ReqOp;
            a   <= ReqA;
            b   <= ReqB;
            acc <= 8'd0;
            cnt <= '0;
          end
        end
        EXEC: begin
          RspData <= AluOut;
          RspEq   <= AluEq;
          RspLt   <= AluLt;
        end
        MUL_ADD: if (b[0]) acc <= AluOut;
        MUL_SHA: a <= AluOut;
        MUL_SHB: begin
          b   <= AluOut;
          cnt <= cnt + CW'(1);
          // acc is final after the last MUL_ADD, so the response is taken from it here.
          if (last_iter) begin
            RspData <= acc;
            RspEq   <= (acc == 8'd0);
            RspLt   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    AluA      = 8'd0;
    AluB      = 8'd0;
    AluOp     = mcADD;
    case (state)
      IDLE: begin
        if (ReqValid) state_nxt = (ReqCmd == CMD_MUL) ? MUL_ADD : EXEC;
      end
      EXEC: begin
        AluA = a;
        AluB = (cmd == CMD_PAR) ? 8'd0 : b;
        case (cmd)
          CMD_CMP: AluOp = mcSUB;
          CMD_PAR: AluOp = mcRXR;
          default: AluOp = op;
        endcase
        state_nxt = RESP;
      end
      MUL_ADD: begin
        AluA      = acc;
        AluB      = a;
        AluOp     = mcADD;
        state_nxt = MUL_SHA;
      end
      MUL_SHA: begin
        AluA      = a;
        AluB      = 8'd1;
        AluOp     = mcLSL;
        state_nxt = MUL_SHB;
      end
      MUL_SHB: begin
        AluA      = b;
        AluB      = 8'd1;
        AluOp     = mcLSR;
        state_nxt = last_iter ? RESP : MUL_ADD;
      end
      RESP: if (RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/alu_mc_sequencer.md
Name: alu_mc_sequencer

Overview:
Initiator side of the combinational ALU interface. Accepts one macro-operation per valid/ready request and drives the ALU operand and opcode lines for one or more cycles. It captures the ALU result and flags, then returns a registered response under a valid/ready handshake. Macro-ops are: single ALU op, 8-bit shift-add multiply (low byte), compare, and parity. It sits between the control/issue stage and the ALU instance.

Parameters:
MUL_ITERS, 8, number of shift-add iterations for MUL; legal range 1..8.

Ports:
Clk  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
ReqValid  in  1  request present
ReqReady  out  1  sequencer can accept a request
ReqCmd  in  2  00 SINGLE, 01 MUL, 10 CMP, 11 PAR
ReqOp  in  3  ALU opcode from the definitions package op_mne (mcADD..mcLSR); used by SINGLE only
ReqA  in  8  operand A
ReqB  in  8  operand B
RspValid  out  1  response present
RspReady  in  1  consumer accepts the response
RspData  out  8  result byte
RspEq  out  1  captured ALU equals flag
RspLt  out  1  captured ALU less-than flag
AluA  out  8  to ALU InputA
AluB  out  8  to ALU InputB
AluOp  out  3  to ALU OP
AluOut  in  8  from ALU Out
AluEq  in  1  from ALU equals flag
AluLt  in  1  from ALU less-than flag

Behaviour:
- States: IDLE, EXEC, MUL_ADD, MUL_SHA, MUL_SHB, RESP.
- Reset (Reset=0, async): state=IDLE. ReqReady=0 while in reset, 1 on the first cycle after release. RspValid=0, RspData=0, RspEq=0, RspLt=0. All internal registers (acc, a, b, iteration count) are cleared.
- ReqReady=1 only in IDLE. Accept = ReqValid && ReqReady at a rising edge. ReqCmd/ReqOp/ReqA/ReqB are latched at accept, so later changes to the inputs are ignored.
- AluA/AluB/AluOp are combinational from state and internal registers. In IDLE and RESP they are 0 / 0 / mcADD.
- SINGLE: IDLE -> EXEC. In EXEC, drive AluA=A, AluB=B, AluOp=ReqOp. At the end of EXEC, capture RspData=AluOut, RspEq=AluEq, RspLt=AluLt, then go to RESP. Latency: RspValid rises 1 cycle after accept.
- CMP: same flow as SINGLE, with AluOp=mcSUB.
- PAR: same flow as SINGLE, with AluOp=mcRXR and AluB=0.
- MUL: at accept, acc=0, a=ReqA, b=ReqB, cnt=0. Then loop MUL_ADD -> MUL_SHA -> MUL_SHB:
  - MUL_ADD: drive (acc, a, mcADD). Set acc=AluOut only if b[0]=1.
  - MUL_SHA: drive (a, 1, mcLSL). Set a=AluOut.
  - MUL_SHB: drive (b, 1, mcLSR). Set b=AluOut and cnt=cnt+1. If cnt+1 == MUL_ITERS, go to RESP; otherwise go to MUL_ADD.
  - Entering RESP: RspData=acc (acc as updated during the last MUL_ADD). RspEq=(acc==0). RspLt=0.
  - Fixed latency of 3*MUL_ITERS cycles (24 by default). No early exit when b==0.
- Overflow: the result is truncated to 8 bits throughout, with no saturation and no carry output.
- RESP: RspValid=1 and RspData/RspEq/RspLt stay stable until RspReady=1 at an edge, then go to IDLE. RspValid=0 from the next cycle on.
- Back-to-back: a new request can be accepted at the earliest 1 cycle after the response handshake. There is no overlap of request and response.
- Response fields keep their last values outside RESP. Only RspValid qualifies them.
- Reset asserted mid-operation aborts immediately. There is no partial response, and the aborted request is not replayed.
- An unknown ReqOp cannot occur, because all 3-bit codes are legal ALU ops.

Test Plan:
- SINGLE mcADD, A=0x3C, B=0x14 -> RspData=0x50, RspEq=0, RspValid 1 cycle after accept; AluOp=mcADD during EXEC.
- MUL A=0x0D, B=0x0B -> RspData=0x8F, RspValid exactly 24 cycles after accept. MUL A=0x20, B=0x10 -> RspData=0x00, RspEq=1 (truncation).
- CMP A=0x55, B=0x55 -> RspEq=1, RspData=0x00. CMP A=0x56, B=0x55 -> RspEq=0, RspData=0x01.
- PAR A=0x07 -> RspData=0x01. PAR A=0x0F -> RspData=0x00. AluB=0 throughout.
- Backpressure: hold RspReady=0 for 5 cycles after RspValid -> RspValid/RspData stable and ReqReady=0. ReqValid held high during this time causes no accept. Raise RspReady -> IDLE, and the next request is accepted 1 cycle later.
- Assert Reset during MUL cycle 10 -> all outputs return to reset values asynchronously. After release, SINGLE mcXOR A=0xFF, B=0x0F -> RspData=0xF0.
